frame_capture: RTL and testbench

FRAME_CAPTURE -- requirements
Module: frame_capture

---
 rtl/frame_capture.sv | 170 +++++++++++++++++
 tb/tb_frame_capture.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_capture.sv
`default_nettype none
// ============================================================================
// Module   : frame_capture
// Purpose  : Ping-pong frame buffer for sensor pixel beats. Defining
//            FRAME_CAPTURE_CHECKSUM_EN adds a per-frame 16-bit pixel checksum.
// Revision : 1.0 - initial release
// ============================================================================
module frame_capture #(
    parameter int PIXEL_BITS = 8,
    parameter int BUS_PIXELS = 8,
    parameter int ROW_PIXELS = 24,
    parameter int ROWS       = 12
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    input  logic [PIXEL_BITS*BUS_PIXELS-1:0] in_data,
    input  logic                             frame_end,
    input  logic                             rd_en,
    input  logic [5:0]                       rd_addr,
    output logic [PIXEL_BITS*BUS_PIXELS-1:0] rd_data,
    input  logic                             frame_release,
    output logic                             frame_ready,
    output logic                             rd_bank,
    output logic                             frame_error,
    output logic [7:0]                       frame_count
`ifdef FRAME_CAPTURE_CHECKSUM_EN
    ,
    output logic [15:0]                      checksum
`endif
);
    localparam int c_width = PIXEL_BITS * BUS_PIXELS;
    localparam int c_beats = ROW_PIXELS / BUS_PIXELS;
    localparam int c_words = ROWS * c_beats;
    localparam int c_cw    = $clog2(c_words + 1);
    localparam int c_mw    = $clog2(2 * c_words);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURE  = 2'd1,
        WAIT_END = 2'd2,
        DISCARD  = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_cw-1:0]    r_word;
    logic               r_wr_bank;
    logic [c_width-1:0] r_mem [0:2*c_words-1];

    logic               w_write;
    logic               w_last;
    logic               w_finish;
    logic               w_accept;
    logic [c_cw-1:0]    w_word;
    logic [c_mw-1:0]    w_wr_idx;
    logic [c_mw-1:0]    w_rd_idx;

    assign w_write  = in_valid && (r_state == IDLE || r_state == CAPTURE);
    assign w_word   = (r_state == IDLE) ? '0 : r_word;
    assign w_last   = (r_state == CAPTURE) && in_valid && (r_word == c_cw'(c_words - 1));
    // A frame finishes on frame_end after its last word, or together with it
    assign w_finish = (w_last && frame_end) ||
                      (r_state == WAIT_END && !in_valid && frame_end);
    assign w_accept = w_finish && (!frame_ready || frame_release);
    assign w_wr_idx = c_mw'(w_word) + (r_wr_bank ? c_mw'(c_words) : '0);
    assign w_rd_idx = c_mw'(rd_addr) + (rd_bank ? c_mw'(c_words) : '0);

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[w_wr_idx] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= (int'(rd_addr) < c_words) ? r_mem[w_rd_idx] : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_word      <= '0;
            r_wr_bank   <= 1'b0;
            rd_bank     <= 1'b1;
            frame_ready <= 1'b0;
            frame_error <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_error <= 1'b0;
            if (frame_release) begin
                frame_ready <= 1'b0;
            end
            if (w_accept) begin
                rd_bank     <= r_wr_bank;
                r_wr_bank   <= ~r_wr_bank;
                frame_ready <= 1'b1;
                frame_count <= frame_count + 8'd1;
            end else if (w_finish) begin
                frame_error <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_word  <= c_cw'(1);
                        r_state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (in_valid) begin
                        r_word <= r_word + c_cw'(1);
                    end
                    if (w_last) begin
                        r_state <= frame_end ? IDLE : WAIT_END;
                    end else if (frame_end) begin
                        frame_error <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                WAIT_END: begin
                    if (in_valid) begin
                        frame_error <= 1'b1;
                        r_state     <= frame_end ? IDLE : DISCARD;
                    end else if (frame_end) begin
                        r_state <= IDLE;
                    end
                end
                DISCARD: begin
                    if (frame_end) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef FRAME_CAPTURE_CHECKSUM_EN
    logic [15:0] w_beat_sum;
    logic [15:0] r_sum;

    always_comb begin
        w_beat_sum = '0;
        for (int i = 0; i < BUS_PIXELS; i++) begin
            w_beat_sum = w_beat_sum + 16'(in_data[i*PIXEL_BITS +: PIXEL_BITS]);
        end
    end

    // Running sum restarts on the first beat of every frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sum    <= '0;
            checksum <= '0;
        end else begin
            if (r_state == IDLE && in_valid) begin
                r_sum <= w_beat_sum;
            end else if (w_write) begin
                r_sum <= r_sum + w_beat_sum;
            end
            if (w_accept) begin
                checksum <= w_last ? (r_sum + w_beat_sum) : r_sum;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_frame_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_capture
// Purpose  : Self-checking bench for frame_capture (directed sequences, read
//            vector table, randomized frames against a frame-level model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_capture;
    localparam int N  = 36;
    localparam int BP = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        frame_end = 1'b0;
    logic        rd_en = 1'b0;
    logic [5:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic        frame_release = 1'b0;
    logic        frame_ready;
    logic        rd_bank;
    logic        frame_error;
    logic [7:0]  frame_count;
`ifdef FRAME_CAPTURE_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    frame_capture dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .frame_end     (frame_end),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .frame_release (frame_release),
        .frame_ready   (frame_ready),
        .rd_bank       (rd_bank),
        .frame_error   (frame_error),
`ifdef FRAME_CAPTURE_CHECKSUM_EN
        .checksum      (checksum),
`endif
        .frame_count   (frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;

    always @(negedge clk) begin
        if (frame_error === 1'b1) err_pulses++;
    end

    typedef struct {
        logic        en;
        logic [5:0]  addr;
        logic [63:0] exp;
    } rvec_t;

    rvec_t       tbl [7];
    logic [63:0] m_bank [2][N];
    logic        m_valid [2];
    logic        m_wr, m_rd, m_ready;
    logic [7:0]  m_count;
    logic [63:0] fr [$];
    int          e0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pat(input int k);
        logic [7:0] b;
        b = 8'(k);
        return {8{b}};
    endfunction

    task automatic beat(input logic [63:0] d, input logic fe);
        in_valid  = 1'b1;
        in_data   = d;
        frame_end = fe;
        tick();
        in_valid  = 1'b0;
        frame_end = 1'b0;
    endtask

    task automatic fend(input logic rel);
        frame_end     = 1'b1;
        frame_release = rel;
        tick();
        frame_end     = 1'b0;
        frame_release = 1'b0;
    endtask

    task automatic release_pulse();
        frame_release = 1'b1;
        tick();
        frame_release = 1'b0;
    endtask

    task automatic send_frame(input int nbeats, input int base);
        for (int k = 0; k < nbeats; k++) beat(pat(k + base), 1'b0);
    endtask

    task automatic status(input string tag, input logic er, input logic eb,
                          input logic [7:0] ec, input int edelta, input int base_err);
        @(negedge clk);
        #1;
        check({tag, " ready"}, 64'(frame_ready), 64'(er));
        check({tag, " rd_bank"}, 64'(rd_bank), 64'(eb));
        check({tag, " count"}, 64'(frame_count), 64'(ec));
        check({tag, " err_pulses"}, 64'(err_pulses - base_err), 64'(edelta));
    endtask

    task automatic rd_check(input string tag, input logic en, input int a, input logic [63:0] exp);
        rd_en   = en;
        rd_addr = 6'(a);
        tick();
        rd_en   = 1'b0;
        check(tag, rd_data, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ready"}, 64'(frame_ready), 64'(0));
        check({tag, " rd_bank"}, 64'(rd_bank), 64'(1));
        check({tag, " error"}, 64'(frame_error), 64'(0));
        check({tag, " count"}, 64'(frame_count), 64'(0));
        check({tag, " rd_data"}, rd_data, 64'(0));
    endtask

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        tbl[0] = '{1'b1, 6'd5,  pat(5)};
        tbl[1] = '{1'b1, 6'd35, pat(35)};
        tbl[2] = '{1'b0, 6'd7,  pat(35)};
        tbl[3] = '{1'b1, 6'd0,  pat(0)};
        tbl[4] = '{1'b1, 6'd17, pat(17)};
        tbl[5] = '{1'b1, 6'd36, 64'd0};
        tbl[6] = '{1'b1, 6'd63, 64'd0};

        repeat (3) tick();
        reset = 1'b0;
        tick();
        check_reset_outputs("reset");

        // Short frame is discarded, next full frame lands in bank 0
        e0 = err_pulses;
        send_frame(20, 0);
        fend(1'b0);
        status("short", 1'b0, 1'b1, 8'd0, 1, e0);

        e0 = err_pulses;
        send_frame(N, 0);
        fend(1'b0);
        status("full1", 1'b1, 1'b0, 8'd1, 0, e0);
        foreach (tbl[i]) rd_check("rd_vec", tbl[i].en, int'(tbl[i].addr), tbl[i].exp);

        e0 = err_pulses;
        send_frame(N, 64);
        fend(1'b0);
        status("dropped", 1'b1, 1'b0, 8'd1, 1, e0);
        rd_check("dropped rd", 1'b1, 5, pat(5));

        e0 = err_pulses;
        send_frame(N, 128);
        fend(1'b1);
        status("rel_coinc", 1'b1, 1'b1, 8'd2, 0, e0);
        rd_check("rel_coinc rd", 1'b1, 5, pat(133));

        release_pulse();
        check("release ready", 64'(frame_ready), 64'(0));

        // Last beat and frame_end in the same cycle
        e0 = err_pulses;
        send_frame(N - 1, 32);
        beat(pat(N - 1 + 32), 1'b1);
        status("merged", 1'b1, 1'b0, 8'd3, 0, e0);
        rd_check("merged rd", 1'b1, 35, pat(67));

        release_pulse();
        e0 = err_pulses;
        send_frame(N + 1, 96);
        fend(1'b0);
        status("long", 1'b0, 1'b0, 8'd3, 1, e0);
        rd_check("long rd", 1'b1, 35, pat(67));
        e0 = err_pulses;
        send_frame(N, 200);
        fend(1'b0);
        status("after_long", 1'b1, 1'b1, 8'd4, 0, e0);

        // Reset in the middle of a capture
        release_pulse();
        send_frame(17, 0);
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        tick();
        reset = 1'b0;
        e0 = err_pulses;
        send_frame(N, 10);
        fend(1'b0);
        status("post_reset", 1'b1, 1'b0, 8'd1, 0, e0);
        rd_check("post_reset rd", 1'b1, 5, pat(15));

        // Randomized frames against a frame-level model
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_wr = 1'b0; m_rd = 1'b1; m_ready = 1'b0; m_count = '0;
        m_valid[0] = 1'b0; m_valid[1] = 1'b0;
        for (int f = 0; f < 30; f++) begin
            int   kind, len, a;
            logic merge, coinc, accept;
            kind  = $urandom_range(0, 7);
            len   = (kind == 0) ? $urandom_range(1, N - 1) :
                    (kind == 1) ? $urandom_range(N + 1, N + 3) : N;
            merge = (len == N) && ($urandom_range(0, 1) == 1);
            coinc = ($urandom_range(0, 3) == 0);
            e0 = err_pulses;
            fr.delete();
            for (int k = 0; k < len; k++) begin
                logic [63:0] d;
                d = {$urandom, $urandom};
                fr.push_back(d);
                if ($urandom_range(0, 4) == 0) tick();
                if (merge && k == len - 1) begin
                    frame_release = coinc;
                    beat(d, 1'b1);
                    frame_release = 1'b0;
                end else begin
                    beat(d, 1'b0);
                end
            end
            if (!merge) fend(coinc);

            accept = (len == N) && (!m_ready || coinc);
            if (accept) begin
                for (int k = 0; k < N; k++) m_bank[m_wr][k] = fr[k];
                m_valid[m_wr] = 1'b1;
                m_rd    = m_wr;
                m_wr    = ~m_wr;
                m_ready = 1'b1;
                m_count = m_count + 8'd1;
            end else if (coinc) begin
                m_ready = 1'b0;
            end
            status("rand", m_ready, m_rd, m_count, accept ? 0 : 1, e0);
            if (m_valid[m_rd]) begin
                a = $urandom_range(0, N - 1);
                rd_check("rand rd", 1'b1, a, m_bank[m_rd][a]);
            end
            if ($urandom_range(0, 1) == 1) begin
                release_pulse();
                m_ready = 1'b0;
            end
        end

`ifdef FRAME_CAPTURE_CHECKSUM_EN
        begin
            int          total;
            logic [15:0] exp_cs;
            reset = 1'b1;
            tick();
            reset = 1'b0;
            check("checksum reset", 64'(checksum), 64'(0));
            total  = N * BP * 255;
            exp_cs = total[15:0];
            for (int k = 0; k < N; k++) beat({64{1'b1}}, 1'b0);
            fend(1'b0);
            check("checksum ff", 64'(checksum), 64'(exp_cs));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
